flit_port_allocator: RTL and testbench

//  Consumer end of the age-sorting permutation network in the bufferless deflection router.

---
 rtl/flit_port_allocator_pkg.sv | 24 ++
 rtl/flit_port_allocator_if.sv | 29 ++
 rtl/flit_port_allocator_slot.sv | 30 +++
 rtl/flit_port_allocator.sv | 93 +++++++++
 tb/tb_flit_port_allocator.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/flit_port_allocator_pkg.sv
// Flit layout, port indices and small helpers shared by the deflection-router port allocator.
package flit_port_allocator_pkg;

  localparam int FLIT_W      = 16;
  localparam int POS_VALID   = 15;
  localparam int POS_PV_HI   = 14;
  localparam int POS_PV_LO   = 11;
  localparam int POS_TIME_HI = 10;
  localparam int POS_TIME_LO = 4;

  localparam int NUM_PORTS = 4;
  localparam int PORT_N    = 0;
  localparam int PORT_E    = 1;
  localparam int PORT_S    = 2;
  localparam int PORT_W    = 3;

  typedef logic [FLIT_W-1:0] flit_t;

  // Isolates the least-significant set bit; zero in gives zero out.
  function automatic logic [NUM_PORTS-1:0] lowest_one(input logic [NUM_PORTS-1:0] x);
    return x & (~x + 4'd1);
  endfunction

endpackage

// File: rtl/flit_port_allocator_if.sv
// Rank inputs, port outputs and control/statistics signals of the port allocator.
interface flit_port_allocator_if
  import flit_port_allocator_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             en;
  logic             clr_cnt;
  flit_t            rank0;
  flit_t            rank1;
  flit_t            rank2;
  flit_t            rank3;
  flit_t            out_n;
  flit_t            out_e;
  flit_t            out_s;
  flit_t            out_w;
  logic [3:0]       defl_map;
  logic [CNT_W-1:0] defl_cnt;

  modport master (
    output en, clr_cnt, rank0, rank1, rank2, rank3,
    input  out_n, out_e, out_s, out_w, defl_map, defl_cnt
  );

  modport slave (
    input  en, clr_cnt, rank0, rank1, rank2, rank3,
    output out_n, out_e, out_s, out_w, defl_map, defl_cnt
  );
endinterface

// File: rtl/flit_port_allocator_slot.sv
// One link of the rank-ordered allocation chain: claims a port for a single flit.
module port_alloc_slot
  import flit_port_allocator_pkg::*;
(
  input  flit_t      flit,
  input  logic [3:0] free_in,
  output logic [3:0] grant,
  output logic [3:0] free_out,
  output logic       defl
);

  logic [3:0] prod;

  always_comb begin
    prod  = flit[POS_PV_HI:POS_PV_LO] & free_in;
    grant = '0;
    defl  = 1'b0;
    if (flit[POS_VALID]) begin
      if (prod != '0) begin
        grant = lowest_one(prod);
      end else begin
        // A valid flit with PV=0 also lands here and is counted as deflected.
        grant = lowest_one(free_in);
        defl  = 1'b1;
      end
    end
    free_out = free_in & ~grant;
  end

endmodule

// File: rtl/flit_port_allocator.sv
// Maps four age-ranked flits onto N/E/S/W through a two-stage pipeline and
// keeps a saturating count of deflected flits.
module flit_port_allocator
  import flit_port_allocator_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  flit_port_allocator_if.slave bus
);

  flit_t [3:0]      rank_in;
  flit_t [3:0]      rank_q;
  flit_t [3:0]      out_d;
  flit_t [3:0]      out_q;
  logic  [3:0]      dm_d;
  logic  [3:0]      dm_q;
  logic  [4:0][3:0] free;
  logic  [3:0][3:0] grant;
  logic  [3:0]      defl;
  logic  [2:0]      pop;
  logic  [CNT_W:0]  sum;
  logic  [CNT_W-1:0] cnt_nxt;
  logic  [CNT_W-1:0] cnt_q;

  assign rank_in = {bus.rank3, bus.rank2, bus.rank1, bus.rank0};
  assign free[0] = 4'hF;

  for (genvar r = 0; r < 4; r++) begin : g_slot
    port_alloc_slot u_slot (
      .flit     (rank_q[r]),
      .free_in  (free[r]),
      .grant    (grant[r]),
      .free_out (free[r+1]),
      .defl     (defl[r])
    );
  end

  // Grants are one-hot per rank and disjoint across ranks, so at most one rank drives each port.
  always_comb begin
    out_d = '0;
    dm_d  = '0;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant[r][p]) begin
          out_d[p] = rank_q[r];
          dm_d[p]  = defl[r];
        end
      end
    end
    dm_d = dm_d & ~free[4];
  end

  always_comb begin
    pop = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      pop = pop + {2'b00, dm_d[p]};
    end
    sum     = {1'b0, cnt_q} + (CNT_W+1)'(pop);
    cnt_nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rank_q <= '0;
      out_q  <= '0;
      dm_q   <= '0;
    end else if (bus.en) begin
      rank_q <= rank_in;
      out_q  <= out_d;
      dm_q   <= dm_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      cnt_q <= '0;
    end else if (bus.en) begin
      cnt_q <= cnt_nxt;
    end
  end

  assign bus.out_n    = out_q[PORT_N];
  assign bus.out_e    = out_q[PORT_E];
  assign bus.out_s    = out_q[PORT_S];
  assign bus.out_w    = out_q[PORT_W];
  assign bus.defl_map = dm_q;
  assign bus.defl_cnt = cnt_q;

endmodule

// File: tb/tb_flit_port_allocator.sv
// Scoreboard bench for flit_port_allocator: expected placements are queued at drive time
// and popped when the pipeline delivers them.
module tb_flit_port_allocator;
  import flit_port_allocator_pkg::*;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    flit_t [3:0] o;
    logic  [3:0] dm;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   mcnt = 0;
  exp_t sb[$];
  exp_t last_exp;

  flit_port_allocator_if #(.CNT_W(TB_CNT_W)) bus ();

  flit_port_allocator #(.CNT_W(TB_CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic flit_t mk(input bit v, input logic [3:0] pv, input logic [6:0] t,
                               input logic [3:0] pay);
    flit_t f;
    f = '0;
    f[POS_VALID] = v;
    f[POS_PV_HI:POS_PV_LO] = pv;
    f[POS_TIME_HI:POS_TIME_LO] = t;
    f[3:0] = pay;
    return f;
  endfunction

  // Reference placement: scan ports in index order, productive first, then any free one.
  function automatic exp_t model(input flit_t [3:0] r);
    exp_t e;
    logic [3:0] fr;
    int pick;
    logic d;
    e = '0;
    fr = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (r[k][POS_VALID]) begin
        pick = -1;
        d = 1'b0;
        for (int p = 0; p < 4; p++)
          if (pick < 0 && fr[p] && r[k][POS_PV_LO+p]) pick = p;
        if (pick < 0) begin
          d = 1'b1;
          for (int p = 0; p < 4; p++)
            if (pick < 0 && fr[p]) pick = p;
        end
        if (pick >= 0) begin
          e.o[pick] = r[k];
          e.dm[pick] = d;
          fr[pick] = 1'b0;
        end
      end
    end
    return e;
  endfunction

  function automatic int popc(input logic [3:0] x);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(x[i]);
    return n;
  endfunction

  task automatic compare_outputs(input string tag);
    chk({tag, ".out_n"}, 64'(bus.out_n), 64'(last_exp.o[0]));
    chk({tag, ".out_e"}, 64'(bus.out_e), 64'(last_exp.o[1]));
    chk({tag, ".out_s"}, 64'(bus.out_s), 64'(last_exp.o[2]));
    chk({tag, ".out_w"}, 64'(bus.out_w), 64'(last_exp.o[3]));
    chk({tag, ".defl_map"}, 64'(bus.defl_map), 64'(last_exp.dm));
    chk({tag, ".defl_cnt"}, 64'(bus.defl_cnt), 64'(mcnt));
  endtask

  task automatic step(input string tag, input flit_t [3:0] r, input logic e, input logic c);
    @(negedge clk);
    bus.rank0 = r[0];
    bus.rank1 = r[1];
    bus.rank2 = r[2];
    bus.rank3 = r[3];
    bus.en = e;
    bus.clr_cnt = c;
    if (e) sb.push_back(model(r));
    @(posedge clk);
    #1;
    if (e) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_underflow"}, 64'd0, 64'd1);
      end else begin
        last_exp = sb.pop_front();
      end
    end
    if (c) mcnt = 0;
    else if (e) mcnt = (mcnt + popc(last_exp.dm) > CNT_MAX) ? CNT_MAX : mcnt + popc(last_exp.dm);
    compare_outputs(tag);
  endtask

  task automatic restart_model();
    sb.delete();
    sb.push_back('0);
    last_exp = '0;
    mcnt = 0;
  endtask

  flit_t [3:0] r;
  flit_t [3:0] zero_r;

  initial begin
    zero_r = '0;
    bus.en = 1'b0;
    bus.clr_cnt = 1'b0;
    bus.rank0 = '0;
    bus.rank1 = '0;
    bus.rank2 = '0;
    bus.rank3 = '0;
    restart_model();
    @(negedge clk);
    @(negedge clk);
    compare_outputs("reset");
    reset_n = 1'b1;

    // No contention: each rank has its own productive port.
    r[0] = mk(1, 4'b0001, 7'd40, 4'h1);
    r[1] = mk(1, 4'b0010, 7'd30, 4'h2);
    r[2] = mk(1, 4'b0100, 7'd20, 4'h3);
    r[3] = mk(1, 4'b1000, 7'd10, 4'h4);
    step("nocont", r, 1'b1, 1'b0);

    // Full contention: everyone wants North.
    r[0] = mk(1, 4'b0001, 7'd50, 4'h5);
    r[1] = mk(1, 4'b0001, 7'd41, 4'h6);
    r[2] = mk(1, 4'b0001, 7'd32, 4'h7);
    r[3] = mk(1, 4'b0001, 7'd23, 4'h8);
    step("fullcont", r, 1'b1, 1'b0);

    // Partial with invalid ranks carrying stale payload.
    r[0] = mk(1, 4'b0100, 7'd60, 4'h9);
    r[1] = mk(0, 4'b1111, 7'd55, 4'hA);
    r[2] = mk(1, 4'b0110, 7'd44, 4'hB);
    r[3] = mk(0, 4'b0001, 7'd33, 4'hC);
    step("partial", r, 1'b1, 1'b0);

    // Valid flit with empty PV plus an all-invalid rank set.
    r[0] = mk(1, 4'b0000, 7'd70, 4'hD);
    r[1] = mk(1, 4'b0001, 7'd12, 4'hE);
    r[2] = '0;
    r[3] = mk(1, 4'b1000, 7'd3, 4'hF);
    step("pvzero", r, 1'b1, 1'b0);
    step("allinv", zero_r, 1'b1, 1'b0);
    step("drain", zero_r, 1'b1, 1'b0);

    // Freeze: new inputs must not enter while en=0.
    r[0] = mk(1, 4'b0001, 7'd1, 4'h1);
    r[1] = mk(1, 4'b0001, 7'd2, 4'h2);
    r[2] = mk(1, 4'b0001, 7'd3, 4'h3);
    r[3] = mk(1, 4'b0001, 7'd4, 4'h4);
    step("fill", r, 1'b1, 1'b0);
    step("fill2", r, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("freeze", zero_r, 1'b0, 1'b0);
    step("clr_frozen", zero_r, 1'b0, 1'b1);

    // Saturation of the 4-bit counter under repeated full contention.
    for (int i = 0; i < 6; i++) step("sat", r, 1'b1, 1'b0);
    step("sat_hold", r, 1'b1, 1'b0);
    step("clr_pri", r, 1'b1, 1'b1);

    // Random traffic with random stalls and clears.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 4; k++) r[k] = flit_t'($urandom);
      step("rand", r, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end

    // Reset in the middle of traffic.
    r[0] = mk(1, 4'b0010, 7'd9, 4'h1);
    r[1] = mk(1, 4'b0010, 7'd8, 4'h2);
    r[2] = mk(1, 4'b0010, 7'd7, 4'h3);
    r[3] = mk(1, 4'b0010, 7'd6, 4'h4);
    step("pre_rst", r, 1'b1, 1'b0);
    step("pre_rst2", r, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    bus.en = 1'b0;
    #1;
    restart_model();
    compare_outputs("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    step("post_rst", zero_r, 1'b1, 1'b0);
    step("post_rst2", r, 1'b1, 1'b0);
    step("flush", zero_r, 1'b1, 1'b0);
    step("flush2", zero_r, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
